// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef enum logic [2:0] {SEQ, BR, JALR, TRAP, MRET} sel_t;

  localparam int unsigned DEFAULT_ILEN = 4;

  // ILEN is a power of two, so ILEN-1 masks exactly the bits that must be zero.
  function automatic int unsigned align_mask(input int unsigned ilen);
    return ilen - 1;
  endfunction

  localparam int unsigned DEFAULT_ALIGN_MASK = align_mask(DEFAULT_ILEN);

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-request handshake plus commit/redirect bus between commit stage, pc_gen and IFU.
interface pc_gen_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             pc_ready;
  logic             commit;
  logic             br_taken;
  logic             jalr;
  logic             trap;
  logic             mret;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] trap_vec;
  logic [WIDTH-1:0] epc;
  logic             misalign;
  logic [WIDTH-1:0] bad_addr;

  modport master (
    output pc, pc_valid, misalign, bad_addr,
    input  pc_ready, commit, br_taken, jalr, trap, mret,
           rs1_data, imm, trap_vec, epc
  );

  modport slave (
    input  pc, pc_valid, misalign, bad_addr,
    output pc_ready, commit, br_taken, jalr, trap, mret,
           rs1_data, imm, trap_vec, epc
  );

endinterface

// File: rtl/adder.sv
// Plain WIDTH-bit adder with carry-in; carry-out is discarded (modulo 2^WIDTH).
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: priority mux, target adders and alignment check.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int unsigned ILEN  = DEFAULT_ILEN
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_taken,
  input  logic             jalr,
  input  logic             trap,
  input  logic             mret,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] target,
  output logic             misalign_raw
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(ILEN));
  localparam logic [WIDTH-1:0] SEQ_INC    = WIDTH'(ILEN);

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_target;
  logic [WIDTH-1:0] seq_target;
  sel_t             sel;

  adder #(.WIDTH(WIDTH)) u_br_add (
    .a   (pc),
    .b   (imm),
    .cin (1'b0),
    .sum (br_target)
  );

  adder #(.WIDTH(WIDTH)) u_jalr_add (
    .a   (rs1_data),
    .b   (imm),
    .cin (1'b0),
    .sum (jalr_sum)
  );

  assign jalr_target = {jalr_sum[WIDTH-1:1], 1'b0};
  assign seq_target  = pc + SEQ_INC;

  always_comb begin
    if (trap)          sel = TRAP;
    else if (mret)     sel = MRET;
    else if (jalr)     sel = JALR;
    else if (br_taken) sel = BR;
    else               sel = SEQ;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    next_pc      = seq_target;
    target       = '0;
    misalign_raw = 1'b0;
    case (sel)
      TRAP: next_pc = trap_vec;
      MRET: next_pc = epc;
      JALR, BR: begin
        target       = (sel == JALR) ? jalr_target : br_target;
        misalign_raw = |(target & ALIGN_MASK);
        next_pc      = misalign_raw ? trap_vec : target;
      end
      default: next_pc = seq_target;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the architectural PC, requests fetches over
// valid/ready and loads the next PC when the fetched instruction commits.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(32'h8000_0000),
  parameter int unsigned      ILEN      = DEFAULT_ILEN
) (
  input logic          clk,
  input logic          rst,
  pc_gen_if.master     bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] bad_addr_q;
  logic             misalign_q;
  logic             load_pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] target;
  logic             misalign_raw;

  pc_next_sel #(.WIDTH(WIDTH), .ILEN(ILEN)) u_next_sel (
    .pc           (pc_q),
    .rs1_data     (bus.rs1_data),
    .imm          (bus.imm),
    .trap_vec     (bus.trap_vec),
    .epc          (bus.epc),
    .br_taken     (bus.br_taken),
    .jalr         (bus.jalr),
    .trap         (bus.trap),
    .mret         (bus.mret),
    .next_pc      (next_pc),
    .target       (target),
    .misalign_raw (misalign_raw)
  );

  // Commit is honoured only in WAIT; in IDLE/REQ it is a protocol error and dropped.
  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (bus.pc_ready) state_d = WAIT;
      WAIT: if (bus.commit) begin
        state_d = REQ;
        load_pc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RST_VALUE;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= load_pc & misalign_raw;
      if (load_pc)                 pc_q       <= next_pc;
      if (load_pc && misalign_raw) bad_addr_q <= target;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = (state_q == REQ);
  assign bus.misalign = misalign_q;
  assign bus.bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed test-plan steps plus randomized commits
// checked against a behavioural next-PC model.
module tb_pc_gen;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] RST_VALUE = 32'h8000_0000;
  localparam int          ILEN      = 4;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_bad;

  pc_gen_if #(.WIDTH(WIDTH)) bus ();

  pc_gen #(.WIDTH(WIDTH), .RST_VALUE(RST_VALUE), .ILEN(ILEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Deassert all commit controls; operand buses carry garbage outside commit cycles.
  task automatic idle_inputs();
    bus.commit   = 1'b0;
    bus.br_taken = 1'b0;
    bus.jalr     = 1'b0;
    bus.trap     = 1'b0;
    bus.mret     = 1'b0;
    bus.rs1_data = $urandom;
    bus.imm      = $urandom;
  endtask

  // Spec-level next-PC rule using wide integer arithmetic reduced modulo 2^32.
  function automatic void model(input logic t, m, j, b,
                                input logic [31:0] cur, rs1, im, tv, ep,
                                output logic [31:0] npc, output logic mis,
                                output logic [31:0] bad);
    longint unsigned base, ofs, tgt;
    base = j ? rs1 : cur;
    ofs  = im;
    mis  = 1'b0;
    bad  = '0;
    if (t)      npc = tv;
    else if (m) npc = ep;
    else if (j || b) begin
      tgt = (base + ofs) % 64'h1_0000_0000;
      if (j) tgt = tgt - (tgt % 2);
      if ((tgt % ILEN) != 0) begin
        mis = 1'b1;
        bad = tgt[31:0];
        npc = tv;
      end else begin
        npc = tgt[31:0];
      end
    end else begin
      base = cur;
      tgt  = (base + ILEN) % 64'h1_0000_0000;
      npc  = tgt[31:0];
    end
  endfunction

  task automatic accept(input int delay);
    bus.pc_ready = 1'b0;
    repeat (delay) step();
    bus.pc_ready = 1'b1;
    step();
    bus.pc_ready = 1'b0;
    check("accept valid_low", 32'(bus.pc_valid), 32'd0);
    check("accept pc_hold", bus.pc, exp_pc);
  endtask

  task automatic commit_txn(input string tag, input logic t, m, j, b,
                            input logic [31:0] rs1, im);
    logic [31:0] npc, bad;
    logic        mis;
    step();
    bus.commit   = 1'b1;
    bus.trap     = t;
    bus.mret     = m;
    bus.jalr     = j;
    bus.br_taken = b;
    bus.rs1_data = rs1;
    bus.imm      = im;
    model(t, m, j, b, exp_pc, rs1, im, bus.trap_vec, bus.epc, npc, mis, bad);
    exp_pc = npc;
    if (mis) exp_bad = bad;
    step();
    idle_inputs();
    check({tag, " valid"}, 32'(bus.pc_valid), 32'd1);
    check({tag, " pc"}, bus.pc, exp_pc);
    check({tag, " misalign"}, 32'(bus.misalign), 32'(mis));
    check({tag, " bad_addr"}, bus.bad_addr, exp_bad);
    step();
    check({tag, " misalign_pulse"}, 32'(bus.misalign), 32'd0);
    check({tag, " pc_stable"}, bus.pc, exp_pc);
  endtask

  initial begin
    logic t, m, j, b;
    logic [31:0] rs1, im;

    rst          = 1'b0;
    bus.pc_ready = 1'b0;
    bus.trap_vec = 32'h8000_0100;
    bus.epc      = 32'h8000_0200;
    idle_inputs();
    repeat (3) step();
    check("reset pc", bus.pc, RST_VALUE);
    check("reset valid", 32'(bus.pc_valid), 32'd0);
    check("reset misalign", 32'(bus.misalign), 32'd0);
    check("reset bad_addr", bus.bad_addr, 32'd0);

    rst = 1'b1;
    check("idle valid", 32'(bus.pc_valid), 32'd0);
    step();
    check("first req valid", 32'(bus.pc_valid), 32'd1);
    check("first req pc", bus.pc, 32'h8000_0000);
    exp_pc  = RST_VALUE;
    exp_bad = '0;

    // Sequential fetch up to 0x80000010.
    for (int i = 0; i < 4; i++) begin
      accept(0);
      commit_txn("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("seq end pc", bus.pc, 32'h8000_0010);

    accept(1);
    commit_txn("branch back", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFF0);
    check("branch back const", bus.pc, 32'h8000_0000);

    accept(0);
    commit_txn("jalr misalign", 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_1001, 32'd2);
    check("jalr misalign bad const", bus.bad_addr, 32'h8000_1002);
    check("jalr misalign pc const", bus.pc, 32'h8000_0100);

    accept(0);
    commit_txn("prio all", 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'd4);
    check("prio all const", bus.pc, 32'h8000_0100);
    accept(0);
    commit_txn("prio no_trap", 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'd4);
    check("prio no_trap const", bus.pc, 32'h8000_0200);

    // Stall in REQ with a stray commit that must be ignored.
    bus.pc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.commit   = (i == 2);
      bus.br_taken = (i == 2);
      bus.imm      = 32'd4;
      step();
      check("stall valid", 32'(bus.pc_valid), 32'd1);
      check("stall pc", bus.pc, exp_pc);
    end
    idle_inputs();
    accept(0);
    commit_txn("after stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Wrap-around: reach 0xFFFFFFFC via an aligned jalr, then step sequentially.
    accept(0);
    commit_txn("jalr top", 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_000C);
    check("jalr top const", bus.pc, 32'hFFFF_FFFC);
    accept(0);
    commit_txn("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("wrap const", bus.pc, 32'h0000_0000);

    // Randomized commits against the behavioural model.
    for (int n = 0; n < 40; n++) begin
      t   = ($urandom_range(0, 7) == 0);
      m   = ($urandom_range(0, 7) == 0);
      j   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 2) == 0);
      rs1 = $urandom;
      im  = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.trap_vec = $urandom;
      bus.epc      = $urandom;
      accept($urandom_range(0, 3));
      commit_txn("random", t, m, j, b, rs1, im);
    end

    // Reset during WAIT coincident with a misaligning commit: reset wins.
    accept(0);
    step();
    rst          = 1'b0;
    bus.commit   = 1'b1;
    bus.br_taken = 1'b1;
    bus.imm      = 32'd2;
    step();
    idle_inputs();
    check("midreset pc", bus.pc, RST_VALUE);
    check("midreset valid", 32'(bus.pc_valid), 32'd0);
    check("midreset misalign", 32'(bus.misalign), 32'd0);
    check("midreset bad_addr", bus.bad_addr, 32'd0);
    rst = 1'b1;
    check("midreset idle", 32'(bus.pc_valid), 32'd0);
    step();
    check("midreset req valid", 32'(bus.pc_valid), 32'd1);
    check("midreset req pc", bus.pc, RST_VALUE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
